// File: rtl/lcd_refresh_ctrl.sv
// HD44780 2x16 refresh controller: owns the 32-byte display buffer, initialises the
// panel in 8-bit write-only mode and streams the buffer to it frame after frame.
module lcd_refresh_ctrl #(
  parameter int unsigned POWERUP_CYCLES = 600000,
  parameter int unsigned EN_CYCLES      = 12,
  parameter int unsigned CMD_CYCLES     = 600,
  parameter int unsigned CLEAR_CYCLES   = 25000,
  parameter int unsigned REFRESH_CYCLES = 1200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] wr_dat,
  input  logic [4:0] wr_addr,
  input  logic       wr_en,
  output logic       update,
  output logic       ready,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_db
);

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned MAX_P = max2(max2(max2(POWERUP_CYCLES, EN_CYCLES),
                                            max2(CMD_CYCLES, CLEAR_CYCLES)), REFRESH_CYCLES);
  localparam int unsigned CW = $clog2(MAX_P + 1);

  localparam logic [CW-1:0] PWR_LD   = CW'(POWERUP_CYCLES - 1);
  localparam logic [CW-1:0] EN_LD    = CW'(EN_CYCLES - 1);
  localparam logic [CW-1:0] CMD_LD   = CW'(CMD_CYCLES - 1);
  localparam logic [CW-1:0] CLEAR_LD = CW'(CLEAR_CYCLES - 1);
  localparam logic [CW-1:0] REF_LD   = CW'(REFRESH_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  typedef enum logic [2:0] {
    S_PWR     = 3'd0,
    S_SETUP   = 3'd1,
    S_EN      = 3'd2,
    S_HOLD    = 3'd3,
    S_REFRESH = 3'd4
  } state_t;

  // Buffer is deliberately outside the reset domain; it powers up as spaces.
  logic [7:0] mem_r [32] = '{default: 8'h20};

  state_t          state_r, state_nx_s;
  logic [CW-1:0]   cnt_r, cnt_nx_s;
  logic [5:0]      idx_r, idx_nx_s;
  logic            frame_r, frame_nx_s;
  logic            ready_set_s;
  logic            update_set_s;
  logic            rs_nx_s;
  logic [7:0]      db_nx_s;
  logic [4:0]      char_addr_s;

  assign lcd_rw = 1'b0;

  // buffer write port, open in every state including reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_dat;
    end
  end

  // next-state: phase sequencing, wait counters and byte index
  always_comb begin
    state_nx_s   = state_r;
    cnt_nx_s     = cnt_r;
    idx_nx_s     = idx_r;
    frame_nx_s   = frame_r;
    ready_set_s  = 1'b0;
    update_set_s = 1'b0;
    case (state_r)
      S_PWR: begin
        if (cnt_r == CNT_ZERO) begin
          state_nx_s = S_SETUP;
          idx_nx_s   = 6'd0;
          frame_nx_s = 1'b0;
        end else begin
          cnt_nx_s = cnt_r - CNT_ONE;
        end
      end
      S_SETUP: begin
        state_nx_s = S_EN;
        cnt_nx_s   = EN_LD;
      end
      S_EN: begin
        if (cnt_r == CNT_ZERO) begin
          state_nx_s = S_HOLD;
          // the clear command needs the long execution wait
          if (!lcd_rs && (lcd_db == 8'h01)) begin
            cnt_nx_s = CLEAR_LD;
          end else begin
            cnt_nx_s = CMD_LD;
          end
        end else begin
          cnt_nx_s = cnt_r - CNT_ONE;
        end
      end
      S_HOLD: begin
        if (cnt_r != CNT_ZERO) begin
          cnt_nx_s = cnt_r - CNT_ONE;
        end else if (!frame_r) begin
          state_nx_s = S_SETUP;
          if (idx_r == 6'd5) begin
            frame_nx_s  = 1'b1;
            idx_nx_s    = 6'd0;
            ready_set_s = 1'b1;
          end else begin
            idx_nx_s = idx_r + 6'd1;
          end
        end else if (idx_r == 6'd33) begin
          state_nx_s   = S_REFRESH;
          cnt_nx_s     = REF_LD;
          update_set_s = 1'b1;
        end else begin
          state_nx_s = S_SETUP;
          idx_nx_s   = idx_r + 6'd1;
        end
      end
      S_REFRESH: begin
        if (cnt_r == CNT_ZERO) begin
          state_nx_s = S_SETUP;
          idx_nx_s   = 6'd0;
        end else begin
          cnt_nx_s = cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_nx_s = S_PWR;
        cnt_nx_s   = PWR_LD;
        idx_nx_s   = 6'd0;
        frame_nx_s = 1'b0;
      end
    endcase
  end

  // byte to present at the upcoming SETUP: init command, DDRAM address or buffer char
  always_comb begin
    rs_nx_s     = 1'b0;
    db_nx_s     = 8'h00;
    char_addr_s = 5'd0;
    if (idx_nx_s <= 6'd16) begin
      char_addr_s = 5'(idx_nx_s - 6'd1);
    end else begin
      char_addr_s = 5'(idx_nx_s - 6'd2);
    end
    if (!frame_nx_s) begin
      case (idx_nx_s)
        6'd0, 6'd1, 6'd2: db_nx_s = 8'h38;
        6'd3:             db_nx_s = 8'h0C;
        6'd4:             db_nx_s = 8'h01;
        6'd5:             db_nx_s = 8'h06;
        default:          db_nx_s = 8'h00;
      endcase
    end else if (idx_nx_s == 6'd0) begin
      db_nx_s = 8'h80;
    end else if (idx_nx_s == 6'd17) begin
      db_nx_s = 8'hC0;
    end else begin
      rs_nx_s = 1'b1;
      db_nx_s = mem_r[char_addr_s];
    end
  end

  // state and registered panel outputs; buffer read is captured on entry to SETUP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_PWR;
      cnt_r   <= PWR_LD;
      idx_r   <= 6'd0;
      frame_r <= 1'b0;
      lcd_e   <= 1'b0;
      lcd_rs  <= 1'b0;
      lcd_db  <= 8'h00;
      ready   <= 1'b0;
      update  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      idx_r   <= idx_nx_s;
      frame_r <= frame_nx_s;
      lcd_e   <= (state_nx_s == S_EN);
      update  <= update_set_s;
      if (ready_set_s) begin
        ready <= 1'b1;
      end
      if (state_nx_s == S_SETUP) begin
        lcd_rs <= rs_nx_s;
        lcd_db <= db_nx_s;
      end
    end
  end

endmodule

// File: doc/lcd_refresh_ctrl.md
Name: lcd_refresh_ctrl

Overview:
- Owns the 32-character display buffer that the binary-to-text formatter writes through its dat/addr/we port.
- Initialises an HD44780-compatible 2x16 character LCD in 8-bit write-only mode, then continuously copies the buffer to the panel.
- After each full frame it pulses update so the formatter regenerates the text. This closes the loop between the lock-in outputs and the display.

Parameters:
POWERUP_CYCLES, 600000, clocks waited after reset before the first command (>=40 ms)
EN_CYCLES, 12, lcd_e high width in clocks (>=450 ns)
CMD_CYCLES, 600, wait after lcd_e falls for normal commands and characters (>=40 us)
CLEAR_CYCLES, 25000, wait after lcd_e falls for the clear command 0x01 (>=1.6 ms)
REFRESH_CYCLES, 1200000, idle clocks between frames

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
wr_dat  in  8  character byte from formatter
wr_addr  in  5  buffer position 0..31; 0..15 is line 1, 16..31 is line 2
wr_en  in  1  buffer write strobe, one byte per cycle
update  out  1  one-cycle pulse requesting the formatter to rewrite the buffer
ready  out  1  high once the init sequence has completed
lcd_rs  out  1  0 = command, 1 = data
lcd_rw  out  1  tied 0 (write only)
lcd_e  out  1  LCD enable strobe
lcd_db  out  8  LCD data bus

Behaviour:
- One clock domain: clk. rst is asynchronous and active-high.
- Reset values: update=0, ready=0, lcd_rs=0, lcd_rw=0, lcd_e=0, lcd_db=0x00.
  - Asserting rst mid-operation forces these values immediately and restarts from PWR.
  - rst does not clear the buffer. Buffer initial contents are 0x20.
- Buffer: 32x8 simple dual-port.
  - Write at posedge when wr_en=1, accepted in every state including during reset release.
  - The sequencer reads with one-cycle registered latency.
  - On a same-address read and write in the same cycle, the read returns the old byte.
- Byte transfer, used for every command and character:
  - SETUP: 1 cycle. lcd_rs and lcd_db are driven, lcd_e=0.
  - EN: EN_CYCLES cycles with lcd_e=1.
  - HOLD: lcd_e=0, lasting CMD_CYCLES, or CLEAR_CYCLES when the byte is command 0x01.
  - lcd_rs and lcd_db stay stable from SETUP through the end of HOLD.
  - Total length: 1+EN_CYCLES+wait.
- State machine:
  - PWR: count POWERUP_CYCLES, then go to INIT.
  - INIT: send commands 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06 in order, all with rs=0. After the last HOLD, set ready=1, which stays high until rst. Go to FRAME.
  - FRAME: send 34 bytes in order:
    - cmd 0x80
    - data buffer[0..15]
    - cmd 0xC0
    - data buffer[16..31]
  - Each character byte is sampled from the buffer at its SETUP cycle. Writes landing after that sample appear in the next frame.
  - After the final HOLD: assert update for exactly 1 cycle, the first cycle of REFRESH.
  - REFRESH: REFRESH_CYCLES idle clocks with lcd_e=0 and lcd_db holding its last value, then FRAME again.
- Frame period: 34*(1+EN_CYCLES+CMD_CYCLES)+REFRESH_CYCLES clocks.
- Counters are sized from the largest parameter. There is no wrap inside a wait, and each counter reloads at every phase entry.
- Buffer addresses presented to the panel wrap only within 0..15 and 16..31 via the two DDRAM set-address commands. No other cursor control is issued.

Test Plan:
(Bench parameters: POWERUP=20, EN=2, CMD=4, CLEAR=8, REFRESH=10.)
- Reset then release -> lcd_e stays 0 for 20 cycles. First SETUP shows rs=0, db=0x38, followed by exactly 2 lcd_e-high cycles.
- Init run -> captured command stream is 38,38,38,0C,01,06. The gap from lcd_e fall after 0x01 to the next SETUP is 8 cycles, 4 for the other commands. ready rises after the 0x06 HOLD.
- Preload buffer with "X: 12345" and "Y: 678" padded with 0x20 -> decoded frame is cmd 80, 16 line-1 chars, cmd C0, 16 line-2 chars. update pulses once, 1 cycle wide.
- Frame timing -> update pulses are spaced 34*7+10=248 cycles apart.
- Write buffer[5]=0x41 during the SETUP cycle of position 5 -> that frame shows the old byte, the next frame shows 0x41.
- Assert rst while lcd_e=1 mid-frame -> lcd_e, rs, db, ready and update drop immediately. After release, the full PWR+INIT sequence repeats and buffer contents are preserved.
